// File: rtl/cam_fifo_pkg.sv
// Shared constants and pixel word layout for the camera capture FIFO.
// Defaults match a 10-bit {pixel, Href, Vsyn} word, 16 entries, divide-by-2 Xclk.
package cam_fifo_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DEPTH_DEF  = 16;
    localparam int DIV_DEF    = 2;

    localparam int PIX_MSB  = 9;
    localparam int PIX_LSB  = 2;
    localparam int HREF_BIT = 1;
    localparam int VSYN_BIT = 0;

    typedef struct packed {
        logic [PIX_MSB-PIX_LSB:0] pixel;
        logic                     href;
        logic                     vsyn;
    } pix_word_t;

endpackage

// File: rtl/div_frec.sv
// Camera master clock generator: clk_in divided by DIV, 50 % duty.
// Latency: Xclk first rises DIV/2 clk_in edges after rst falls.
// No backpressure; free-running while rst is low.
module div_frec
    import cam_fifo_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk_in,
    input  logic rst,
    output logic Xclk
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt  <= '0;
            Xclk <= 1'b0;
        end else if (cnt == HALF_M1) begin
            cnt  <= '0;
            Xclk <= ~Xclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cam_fifo.sv
// Pixel capture FIFO on Pclk plus the Xclk divider; optional count port via CAM_FIFO_COUNT_EN.
// Latency: read data registered on the accepting edge; flags reflect post-edge occupancy.
// Backpressure: writes dropped while full (unless a read frees a slot), reads ignored while empty.
module cam_fifo
    import cam_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DIV    = DIV_DEF
) (
    input  logic              Pclk,
    input  logic              rst,
    input  logic              clk_in,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              Xclk
`ifdef CAM_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     occ_nxt;
    logic              rd_ok;
    logic              wr_ok;

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    always_comb begin
        rd_ok   = rd && !empty;
        wr_ok   = wr && (!full || rd_ok);
        occ_nxt = occ;
        case ({wr_ok, rd_ok})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            data_out <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            occ   <= occ_nxt;
            empty <= (occ_nxt == '0);
            full  <= (occ_nxt == DEPTH_C);
        end
    end

    // Storage is deliberately left out of reset; only the pointers are cleared.
    always_ff @(posedge Pclk) begin
        if (!rst && wr_ok) mem[wr_ptr] <= data_in;
    end

`ifdef CAM_FIFO_COUNT_EN
    assign count = occ;
`endif

    div_frec #(
        .DIV (DIV)
    ) u_div_frec (
        .clk_in (clk_in),
        .rst    (rst),
        .Xclk   (Xclk)
    );

endmodule

// File: tb/tb_cam_fifo.sv
// Randomized and directed checks of cam_fifo against a queue-based reference model.
module tb_cam_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 10;

    logic          Pclk = 1'b0;
    logic          clk_in = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          xclk2;
    logic [DW-1:0] data_out4;
    logic          empty4;
    logic          full4;
    logic          xclk4;
`ifdef CAM_FIFO_COUNT_EN
    logic [4:0]    count;
    logic [4:0]    count4;
`endif

    always #5 Pclk = ~Pclk;
    always #3 clk_in = ~clk_in;

    cam_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .DIV(2)) dut (
        .Pclk     (Pclk),
        .rst      (rst),
        .clk_in   (clk_in),
        .wr       (wr),
        .rd       (rd),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .Xclk     (xclk2)
`ifdef CAM_FIFO_COUNT_EN
        , .count  (count)
`endif
    );

    cam_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .DIV(4)) dut_div4 (
        .Pclk     (Pclk),
        .rst      (rst),
        .clk_in   (clk_in),
        .wr       (1'b0),
        .rd       (1'b0),
        .data_in  ('0),
        .data_out (data_out4),
        .empty    (empty4),
        .full     (full4),
        .Xclk     (xclk4)
`ifdef CAM_FIFO_COUNT_EN
        , .count  (count4)
`endif
    );

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One Pclk cycle: drive on the falling edge, update the model at the rising edge, check after it.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit rda;
        bit wra;
        @(negedge Pclk);
        wr = w; rd = r; data_in = d; rst = rs;
        @(posedge Pclk);
        if (rs) begin
            q.delete();
            m_dout = '0;
        end else begin
            rda = r && (q.size() != 0);
            wra = w && ((q.size() < DEPTH) || rda);
            if (rda) m_dout = q.pop_front();
            if (wra) q.push_back(d);
        end
        #1;
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef CAM_FIFO_COUNT_EN
        chk("count", 32'(count), 32'(q.size()));
`endif
    endtask

    initial begin
        int pw;
        int pr;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
        m_dout = '0;

        // Divider held at 0 in reset, then toggles every DIV/2 clk_in edges.
        @(negedge clk_in);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk_in); #1;
            chk("xclk2_in_rst", 32'(xclk2), 32'd0);
            chk("xclk4_in_rst", 32'(xclk4), 32'd0);
        end
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            chk("xclk2_wave", 32'(xclk2), 32'(k % 2));
            chk("xclk4_wave", 32'(xclk4), 32'((k / 2) % 2));
        end

        @(negedge Pclk); #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_empty_div4", 32'(empty4), 32'd1);

        // Fill, overflow attempt, drain in order.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
        chk("full_after_16", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 10'h3FF, 1'b0);
        chk("full_after_drop", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, '0, 1'b0);
            chk("drain_order", 32'(data_out), 32'(i));
        end
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Reads on empty leave data_out alone.
        cyc(1'b0, 1'b1, '0, 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("rd_empty_hold", 32'(data_out), 32'h010);

        // Simultaneous read/write when full, then wrap-around readback.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
        cyc(1'b1, 1'b1, 10'h2AA, 1'b0);
        chk("full_rw_dout", 32'(data_out), 32'h001);
        chk("full_rw_full", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, '0, 1'b0);
        chk("wrap_last", 32'(data_out), 32'h2AA);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous read/write when empty: only the write lands.
        cyc(1'b1, 1'b1, 10'h155, 1'b0);
        chk("empty_rw_dout", 32'(data_out), 32'h2AA);
        chk("empty_rw_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("empty_rw_read", 32'(data_out), 32'h155);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(10'h100 + i), 1'b0);
        cyc(1'b1, 1'b1, 10'h0AA, 1'b1);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("rst_mid_noread", 32'(data_out), 32'd0);
        chk("rst_mid_empty2", 32'(empty), 32'd1);

        // Random traffic in fill / drain / balanced phases with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 50; pr = 50; end
            endcase
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                DW'($urandom), $urandom_range(0, 199) == 0);
        end
        cyc(1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
